// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline boundary: two-entry (main + skid) buffer between fetch and decode.
// Presents a NOP bubble when empty and latches HALT to stop further fetch acceptance.
module fetch_decode_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]       HALT_OPC  = 5'b00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [WIDTH-1:0] if_instr,
  input  logic [WIDTH-1:0] if_pc_next,
  output logic             if_ready,
  input  logic             flush,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_instr,
  output logic [WIDTH-1:0] id_pc_next,
  output logic             halt_pend
);

  logic             main_valid, main_valid_nxt;
  logic [WIDTH-1:0] main_instr, main_instr_nxt;
  logic [WIDTH-1:0] main_pc,    main_pc_nxt;
  logic             skid_valid, skid_valid_nxt;
  logic [WIDTH-1:0] skid_instr, skid_instr_nxt;
  logic [WIDTH-1:0] skid_pc,    skid_pc_nxt;
  logic             halt_q,     halt_nxt;

  logic accept;
  logic pop;
  logic is_halt;

  // rst_n gates if_ready so fetch never advances while the buffer is held in reset.
  assign if_ready   = rst_n & ~skid_valid & ~halt_q;
  assign accept     = if_valid & if_ready;
  assign pop        = main_valid & id_ready;
  assign is_halt    = (if_instr[WIDTH-1 -: 5] == HALT_OPC);

  assign id_valid   = main_valid;
  assign id_instr   = main_valid ? main_instr : NOP_INSTR;
  assign id_pc_next = main_pc;
  assign halt_pend  = halt_q;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path through
    // the case below can leave one unassigned and infer a latch.
    main_valid_nxt = main_valid;
    main_instr_nxt = main_instr;
    main_pc_nxt    = main_pc;
    skid_valid_nxt = skid_valid;
    skid_instr_nxt = skid_instr;
    skid_pc_nxt    = skid_pc;
    halt_nxt       = halt_q;

    if (flush) begin
      // Payload registers keep their contents so id_pc_next holds its last value.
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
      halt_nxt       = 1'b0;
    end else begin
      unique case ({skid_valid, main_valid})
        2'b00: begin
          if (accept) begin
            main_valid_nxt = 1'b1;
            main_instr_nxt = if_instr;
            main_pc_nxt    = if_pc_next;
          end
        end
        2'b01: begin
          if (pop && accept) begin
            main_instr_nxt = if_instr;
            main_pc_nxt    = if_pc_next;
          end else if (pop) begin
            main_valid_nxt = 1'b0;
          end else if (accept) begin
            skid_valid_nxt = 1'b1;
            skid_instr_nxt = if_instr;
            skid_pc_nxt    = if_pc_next;
          end
        end
        2'b11: begin
          if (pop) begin
            main_instr_nxt = skid_instr;
            main_pc_nxt    = skid_pc;
            skid_valid_nxt = 1'b0;
          end
        end
        default: begin
          // Skid without main is unreachable; recover to empty.
          main_valid_nxt = 1'b0;
          skid_valid_nxt = 1'b0;
        end
      endcase

      if (accept && is_halt) begin
        halt_nxt = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_instr <= '0;
      main_pc    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      halt_q     <= 1'b0;
    end else begin
      main_valid <= main_valid_nxt;
      main_instr <= main_instr_nxt;
      main_pc    <= main_pc_nxt;
      skid_valid <= skid_valid_nxt;
      skid_instr <= skid_instr_nxt;
      skid_pc    <= skid_pc_nxt;
      halt_q     <= halt_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Self-checking bench for fetch_decode_reg: a driver pushes accepted words into a
// scoreboard queue; a negedge monitor pops and compares whatever decode consumes.
module tb_fetch_decode_reg;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_next;
  logic        if_ready;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc_next;
  logic        halt_pend;

  fetch_decode_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc_next (if_pc_next),
    .if_ready   (if_ready),
    .flush      (flush),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc_next (id_pc_next),
    .halt_pend  (halt_pend)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];   // {instr, pc_next} of words accepted, oldest first
  int          cnt_m;      // model occupancy of the DUT buffer
  logic        halt_m;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Called #1 after a rising edge: checks handshake state against the model,
  // drives one cycle of inputs, updates the model and advances to the next edge.
  task automatic cycle(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic rdy, input logic fl);
    logic exp_ready;
    logic pop_m;
    logic acc_m;
    exp_ready = (cnt_m < 2) && !halt_m;
    check("if_ready", {31'b0, if_ready}, {31'b0, exp_ready});
    check("id_valid", {31'b0, id_valid}, {31'b0, cnt_m > 0});
    check("halt_pend", {31'b0, halt_pend}, {31'b0, halt_m});
    check("occupancy<=2", {31'b0, cnt_m <= 2}, 32'd1);
    if_valid   = v;
    if_instr   = ins;
    if_pc_next = pc;
    id_ready   = rdy;
    flush      = fl;
    pop_m = (cnt_m > 0) && rdy;
    acc_m = v && exp_ready;
    if (fl) begin
      exp_q.delete();
      cnt_m  = 0;
      halt_m = 1'b0;
    end else begin
      cnt_m = cnt_m - int'(pop_m) + int'(acc_m);
      if (acc_m) begin
        exp_q.push_back({ins, pc});
        if (ins[15:11] == 5'b00000) halt_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the head word whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (id_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {id_instr, id_pc_next}, 32'hxxxx_xxxx);
        end else begin
          check("head_word", {id_instr, id_pc_next}, exp_q[0]);
          if (id_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("bubble_nop", {16'h0, id_instr}, {16'h0, NOP});
      end
    end
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc_next = '0;
    flush = 1'b0; id_ready = 1'b0;
    cnt_m = 0; halt_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_id_instr", {16'h0, id_instr}, {16'h0, NOP});
    check("rst_id_pc", {16'h0, id_pc_next}, 32'd0);
    check("rst_if_ready", {31'b0, if_ready}, 32'd0);
    check("rst_halt", {31'b0, halt_pend}, 32'd0);
    rst_n = 1'b1;
    #1;

    // 1: basic single-cycle latency
    cycle(1'b1, 16'h4025, 16'h0002, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    check("pc_holds_when_empty", {16'h0, id_pc_next}, 32'h0002);

    // 2: stall fills skid, then drain in order
    cycle(1'b1, 16'hA001, 16'h0010, 1'b0, 1'b0);
    cycle(1'b1, 16'hA002, 16'h0012, 1'b0, 1'b0);
    cycle(1'b1, 16'hA003, 16'h0014, 1'b0, 1'b0);  // ignored: buffer full
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // 1-entry simultaneous pop & accept (streaming)
    cycle(1'b1, 16'h5101, 16'h0020, 1'b1, 1'b0);
    cycle(1'b1, 16'h5102, 16'h0022, 1'b1, 1'b0);
    cycle(1'b1, 16'h5103, 16'h0024, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // 3: flush with two entries held and a same-cycle fetch
    cycle(1'b1, 16'hC001, 16'h0030, 1'b0, 1'b0);
    cycle(1'b1, 16'hC002, 16'h0032, 1'b0, 1'b0);
    cycle(1'b1, 16'hB0B0, 16'h0034, 1'b0, 1'b1);
    check("flush_nop", {16'h0, id_instr}, {16'h0, NOP});
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // 4: HALT delivered, blocks fetch until flush
    cycle(1'b1, 16'h0000, 16'h0040, 1'b1, 1'b0);
    cycle(1'b1, 16'h1234, 16'h0042, 1'b1, 1'b0);  // ignored: halt pending
    cycle(1'b1, 16'h1235, 16'h0044, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    cycle(1'b1, 16'h6001, 16'h0050, 1'b1, 1'b0);
    // flush wins over a same-cycle HALT accept
    cycle(1'b1, 16'h0000, 16'h0052, 1'b1, 1'b1);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // 5: asynchronous reset mid-cycle with two entries held
    cycle(1'b1, 16'hD001, 16'h0060, 1'b0, 1'b0);
    cycle(1'b1, 16'hD002, 16'h0062, 1'b0, 1'b0);
    check("pre_reset_full", {31'b0, id_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_id_valid", {31'b0, id_valid}, 32'd0);
    check("async_id_instr", {16'h0, id_instr}, {16'h0, NOP});
    check("async_id_pc", {16'h0, id_pc_next}, 32'd0);
    check("async_if_ready", {31'b0, if_ready}, 32'd0);
    exp_q.delete();
    cnt_m = 0;
    halt_m = 1'b0;
    if_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // 6: random traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end
    repeat (3) cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    check("all_words_delivered", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
